// File: rtl/rtc_defs.sv
// Shared definitions for the RTC register sequencer.
// Holds the RTC register address map, the default transfer-command
// address, strobe polarity and a_d encodings, and the FSM state types.
package rtc_defs;

  localparam logic [7:0] RTC_SEG      = 8'h21;
  localparam logic [7:0] RTC_MIN      = 8'h22;
  localparam logic [7:0] RTC_HORA     = 8'h23;
  localparam logic [7:0] RTC_DIA      = 8'h24;
  localparam logic [7:0] RTC_MES      = 8'h25;
  localparam logic [7:0] RTC_ANIO     = 8'h26;
  localparam logic [7:0] RTC_SEG_TIM  = 8'h41;
  localparam logic [7:0] RTC_MIN_TIM  = 8'h42;
  localparam logic [7:0] RTC_HORA_TIM = 8'h43;

  localparam logic [7:0] RTC_CMD_ADDR = 8'hF0;

  // Index 0 sits in the low byte.
  localparam logic [71:0] RTC_DEFAULT_TABLE = {
    RTC_HORA_TIM, RTC_MIN_TIM, RTC_SEG_TIM, RTC_ANIO, RTC_MES,
    RTC_DIA, RTC_HORA, RTC_MIN, RTC_SEG};

  localparam logic STROBE_ON  = 1'b0;
  localparam logic STROBE_OFF = 1'b1;
  localparam logic AD_ADDR    = 1'b0;
  localparam logic AD_DATA    = 1'b1;

  typedef enum logic [1:0] {IDLE, CMD, REG, FIN} seq_state_t;
  typedef enum logic [2:0] {B_IDLE, B_ADDR, B_GAP1, B_DATA, B_GAP2} bus_state_t;

endpackage

// File: rtl/rtc_bus_cycle.sv
// Single RTC bus-cycle engine: address phase, gap, optional data phase, gap.
// Ports: go/addr_only/rnw/addr/wdata request an access; ack marks the last
// cycle of an access (a new go may be accepted in that cycle for a
// seamless chain); rdata/rdata_valid return read data; cs/rd/wr/a_d/
// ad_out/ad_oe/ad_in are the RTC bus pins.
//
// state  | meaning
// B_IDLE | no access, strobes inactive
// B_ADDR | address phase, address driven
// B_GAP1 | strobes released after address
// B_DATA | data phase, read or write strobe active
// B_GAP2 | strobes released after data
module rtc_bus_cycle
  import rtc_defs::*;
#(
  parameter int DATA_W  = 8,
  parameter int T_PHASE = 8,
  parameter int T_GAP   = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              go,
  input  logic              addr_only,
  input  logic              rnw,
  input  logic [DATA_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ack,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_valid,
  output logic              cs,
  output logic              rd,
  output logic              wr,
  output logic              a_d,
  output logic [DATA_W-1:0] ad_out,
  output logic              ad_oe,
  input  logic [DATA_W-1:0] ad_in
);

  localparam int T_MAX = (T_PHASE > T_GAP) ? T_PHASE : T_GAP;
  localparam int CNT_W = (T_MAX > 1) ? $clog2(T_MAX) : 1;
  localparam logic [CNT_W-1:0] PHASE_LOAD = CNT_W'(T_PHASE - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(T_GAP - 1);

  bus_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rnw_q, addr_only_q;
  logic              last, launch, capture;
  logic              cs_d, rd_d, wr_d, a_d_d, oe_d;
  logic [DATA_W-1:0] ad_out_d;

  assign last = (cnt_q == '0);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ack      = 1'b0;
    launch   = 1'b0;
    capture  = 1'b0;
    ad_out_d = ad_out;
    if (state_q != B_IDLE && !last) cnt_d = cnt_q - 1'b1;
    case (state_q)
      B_IDLE: launch = go;
      B_ADDR: if (last) begin
        state_d = B_GAP1;
        cnt_d   = GAP_LOAD;
      end
      B_GAP1: if (last) begin
        if (addr_only_q) begin
          ack    = 1'b1;
          launch = go;
          if (!go) state_d = B_IDLE;
        end else begin
          state_d = B_DATA;
          cnt_d   = PHASE_LOAD;
          if (!rnw_q) ad_out_d = wdata;
        end
      end
      B_DATA: if (last) begin
        state_d = B_GAP2;
        cnt_d   = GAP_LOAD;
        capture = rnw_q;
      end
      B_GAP2: if (last) begin
        ack    = 1'b1;
        launch = go;
        if (!go) state_d = B_IDLE;
      end
      default: state_d = B_IDLE;
    endcase
    if (launch) begin
      state_d  = B_ADDR;
      cnt_d    = PHASE_LOAD;
      ad_out_d = addr;
    end
    // Pins are registered from the next state so they change with the state.
    cs_d  = (state_d == B_ADDR || state_d == B_DATA) ? STROBE_ON : STROBE_OFF;
    a_d_d = (state_d == B_ADDR) ? AD_ADDR : AD_DATA;
    wr_d  = (state_d == B_ADDR || (state_d == B_DATA && !rnw_q)) ? STROBE_ON : STROBE_OFF;
    rd_d  = (state_d == B_DATA && rnw_q) ? STROBE_ON : STROBE_OFF;
    oe_d  = (state_d == B_ADDR) || (state_d == B_DATA && !rnw_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= B_IDLE;
      cnt_q       <= '0;
      rnw_q       <= 1'b1;
      addr_only_q <= 1'b0;
      cs          <= STROBE_OFF;
      rd          <= STROBE_OFF;
      wr          <= STROBE_OFF;
      a_d         <= AD_DATA;
      ad_oe       <= 1'b0;
      ad_out      <= '0;
      rdata       <= '0;
      rdata_valid <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      if (launch) begin
        rnw_q       <= rnw;
        addr_only_q <= addr_only;
      end
      cs          <= cs_d;
      rd          <= rd_d;
      wr          <= wr_d;
      a_d         <= a_d_d;
      ad_oe       <= oe_d;
      ad_out      <= ad_out_d;
      rdata_valid <= capture;
      if (capture) rdata <= ad_in;
    end
  end

endmodule

// File: rtl/rtc_seq_access.sv
// Register-sequencing controller for the multiplexed-bus RTC.
// Ports: start/mode request a read (0) or write (1) burst over N_REGS table
// entries; busy/done report progress; idx selects the register, wr_data
// supplies write data, rd_data/rd_valid return read data; cs/rd/wr/a_d/
// ad_out/ad_oe/ad_in are the RTC bus pins driven by rtc_bus_cycle.
//
// state | meaning
// IDLE  | waiting for start
// CMD   | address-only transfer command before a read burst
// REG   | full access of register idx
// FIN   | one-cycle done, start ignored
module rtc_seq_access
  import rtc_defs::*;
#(
  parameter int                       N_REGS     = 9,
  parameter int                       DATA_W     = 8,
  parameter logic [N_REGS*DATA_W-1:0] ADDR_TABLE = RTC_DEFAULT_TABLE,
  parameter bit                       CMD_EN     = 1'b1,
  parameter logic [DATA_W-1:0]        CMD_ADDR   = RTC_CMD_ADDR,
  parameter int                       T_PHASE    = 8,
  parameter int                       T_GAP      = 2,
  localparam int                      IDX_W      = (N_REGS > 1) ? $clog2(N_REGS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mode,
  output logic              busy,
  output logic              done,
  output logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              a_d,
  output logic              cs,
  output logic              rd,
  output logic              wr,
  output logic [DATA_W-1:0] ad_out,
  output logic              ad_oe,
  input  logic [DATA_W-1:0] ad_in
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REGS - 1);

  seq_state_t        state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              mode_q, mode_d;
  logic              go, go_addr_only, go_rnw, ack;
  logic [DATA_W-1:0] go_addr;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    mode_d       = mode_q;
    go           = 1'b0;
    go_addr_only = 1'b0;
    go_rnw       = ~mode_q;
    case (state_q)
      IDLE: if (start) begin
        go     = 1'b1;
        mode_d = mode;
        go_rnw = ~mode;
        if (!mode && CMD_EN) begin
          go_addr_only = 1'b1;
          state_d      = CMD;
        end else begin
          state_d = REG;
        end
      end
      CMD: if (ack) begin
        go      = 1'b1;
        state_d = REG;
      end
      REG: if (ack) begin
        if (idx_q == LAST_IDX) begin
          state_d = FIN;
        end else begin
          idx_d = idx_q + 1'b1;
          go    = 1'b1;
        end
      end
      FIN: begin
        state_d = IDLE;
        idx_d   = '0;
      end
      default: state_d = IDLE;
    endcase
    // The next access is launched in the ack cycle, so address from idx_d.
    go_addr = go_addr_only ? CMD_ADDR : ADDR_TABLE[int'(idx_d)*DATA_W +: DATA_W];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      mode_q  <= mode_d;
    end
  end

  assign busy = (state_q == CMD) || (state_q == REG);
  assign done = (state_q == FIN);
  assign idx  = idx_q;

  rtc_bus_cycle #(
    .DATA_W (DATA_W),
    .T_PHASE(T_PHASE),
    .T_GAP  (T_GAP)
  ) u_bus (
    .clk        (clk),
    .reset      (reset),
    .go         (go),
    .addr_only  (go_addr_only),
    .rnw        (go_rnw),
    .addr       (go_addr),
    .wdata      (wr_data),
    .ack        (ack),
    .rdata      (rd_data),
    .rdata_valid(rd_valid),
    .cs         (cs),
    .rd         (rd),
    .wr         (wr),
    .a_d        (a_d),
    .ad_out     (ad_out),
    .ad_oe      (ad_oe),
    .ad_in      (ad_in)
  );

endmodule

// File: doc/rtc_seq_access.md
# rtc_seq_access

Parametrised register-sequencing controller for the parallel multiplexed-bus RTC. One `start` pulse reads or writes a configurable list of RTC registers in ascending index order. An optional transfer command (address-only access) precedes a read burst. It drives the RTC control strobes directly through an internal bus-cycle engine, sits between the top-level control FSM and the time/date/timer register bank, and replaces the fixed nine-register, counter-windowed read sequencer.

## Interface
Parameters:
- `N_REGS`, 9: number of registers per burst (≥1).
- `DATA_W`, 8: bus width for both address and data.
- `ADDR_TABLE`, {8'h43,8'h42,8'h41,8'h26,8'h25,8'h24,8'h23,8'h22,8'h21}: flattened `N_REGS*DATA_W` vector. Index i is at bits `[i*DATA_W +: DATA_W]`. Defaults in index order are seg, min, hora, dia, mes, anio, seg_tim, min_tim, hora_tim.
- `CMD_EN`, 1: issue the transfer command before a read burst.
- `CMD_ADDR`, 8'hF0: transfer command address.
- `T_PHASE`, 8: cycles per strobe phase (≥2).
- `T_GAP`, 2: idle cycles after each phase (≥1).

Ports:
- `clk`  in  1: system clock.
- `reset`  in  1: asynchronous, active-low reset.
- `start`  in  1: burst request. Sampled only in IDLE.
- `mode`  in  1: 0 = read, 1 = write. Sampled with `start`.
- `busy`  out  1: burst in progress.
- `done`  out  1: one-cycle pulse when a burst ends.
- `idx`  out  `$clog2(N_REGS)`: index of the register being accessed.
- `wr_data`  in  DATA_W: write value for `idx`.
- `rd_data`  out  DATA_W: captured read value.
- `rd_valid`  out  1: one-cycle pulse. `rd_data`/`idx` are valid.
- `a_d`  out  1: 0 = address phase, 1 = data phase.
- `cs`, `rd`, `wr`  out  1 each: active-low RTC strobes.
- `ad_out`  out  DATA_W: bus drive value.
- `ad_oe`  out  1: bus tristate enable.
- `ad_in`  in  DATA_W: bus sample.

## Operation
- Top FSM states: IDLE, CMD, REG, FIN.
- IDLE → CMD on `start` when `mode`=0 and `CMD_EN`=1. IDLE → REG otherwise on `start`.
- CMD performs one address-only access to `CMD_ADDR`, then enters REG with `idx`=0.
- REG performs one full access for `idx`. At the end it increments `idx`, or goes to FIN when `idx`=`N_REGS`-1.
- FIN lasts one cycle with `done`=1 and `busy`=0, then returns to IDLE.
- Bus-cycle engine states: B_IDLE, B_ADDR, B_GAP1, B_DATA, B_GAP2. Each phase is timed by a down-counter.
- B_ADDR (`T_PHASE` cycles): `cs`=0, `a_d`=0, `wr`=0, `ad_oe`=1, `ad_out`=table address.
- B_GAP1 (`T_GAP` cycles): all strobes high, `ad_oe`=0. An address-only access ends here.
- B_DATA read (`T_PHASE` cycles): `cs`=0, `a_d`=1, `rd`=0, `ad_oe`=0. `ad_in` is registered on the last B_DATA cycle.
- B_DATA write (`T_PHASE` cycles): `cs`=0, `a_d`=1, `wr`=0, `ad_oe`=1. `ad_out` holds `wr_data` registered on the last B_GAP1 cycle.
- B_GAP2 (`T_GAP` cycles): strobes high, `ad_oe`=0. `rd_valid` pulses on the first B_GAP2 cycle, in read mode only.
- `start` while `busy` is ignored. `mode` is latched at start and held for the whole burst.
- `wr_data` must be stable while `idx` is constant; it is only sampled as described above.
- `idx` wraps only via the return to IDLE, never by modular increment.

## Timing
- Reset values (asynchronous, on `reset`=0): `busy`=0, `done`=0, `rd_valid`=0, `idx`=0, `rd_data`=0, `cs`=`rd`=`wr`=1, `a_d`=1, `ad_oe`=0, `ad_out`=0. Both FSMs return to their idle states.
- Reset mid-burst drops all strobes immediately. No `done` is issued.
- Strobes are registered outputs with no combinational path from inputs.
- `start` is sampled at cycle 0. `cs` falls at cycle 1.
- Register access length is 2·(`T_PHASE`+`T_GAP`) = 20 cycles at defaults. Command access length is `T_PHASE`+`T_GAP` = 10 cycles.
- Default read burst: `busy` high for cycles 1–190, `done` at cycle 191.
- Default write burst: `busy` high for cycles 1–180, `done` at cycle 181.
- `start` arriving in the FIN cycle is ignored. It is accepted one cycle later.

## Structure
- Shared package/header `rtc_defs`: RTC register addresses, `CMD_ADDR` default, strobe polarity constants, `a_d` encodings.
- One sub-module, `rtc_bus_cycle`:
  - Inputs: `go`, `addr_only`, `rnw`, `addr`, `wdata`.
  - Outputs: `ack`, `rdata`, `rdata_valid`, plus all bus pins.
  - It owns the phase counter.
- The top module owns the burst FSM, `idx`, and the mode latch.

## Test plan
- Reset mid-B_DATA of read index 3 → strobes = 1 and `ad_oe` = 0 within the same cycle. No `done`. The next `start` begins cleanly with `idx`=0.
- Default read with a bus model returning 8'h10+i for address table entry i:
  - `cs` low at cycle 1, first address 8'hF0 with no data phase.
  - Nine `rd_valid` pulses carry 8'h10…8'h18 with `idx` 0…8.
  - `done` at cycle 191.
- Default write with `wr_data` = {idx, 4'hA}:
  - No command access.
  - Bus shows addresses 8'h21…8'h43, each followed by 8'h0A…8'h8A with `wr` low in the data phase.
  - `done` at cycle 181. No `rd_valid`.
- `start` pulses at cycles 50 and 191 during a read → both ignored. Only one `done`.
- `N_REGS`=1, `CMD_EN`=0, `T_PHASE`=2, `T_GAP`=1, read → `busy` for 6 cycles, one `rd_valid`, `done` at cycle 7.
- Back-to-back: `start` held high continuously → bursts repeat with exactly 2 idle cycles (FIN + IDLE) between the last B_GAP2 and the next `cs` fall.
